// File: rtl/hongwai_uart_rx.sv
// hongwai_uart_rx
//   8N1, LSB-first UART receiver feeding the infrared frame parser.
//   The parser latches data_rx on the falling edge of rx_int. data_rx is
//   therefore updated on the same edge that drops rx_int.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rs232_rx   asynchronous serial input, idles high
//   data_rx    last received byte, held until the next completed frame
//   rx_int     high while a verified frame is being received
//   frame_err  one-cycle pulse when the stop bit samples low
module hongwai_uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] data_rx,
  output logic       rx_int,
  output logic       frame_err
);

  localparam int BPS_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BPS_CNT / 2;
  localparam int CW       = $clog2(BPS_CNT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [CW-1:0] bps_cnt_q, bps_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        rx_int_q, rx_int_d;
  logic        ferr_q, ferr_d;

  logic start_edge;
  logic rx_sync;
  logic sample;

  assign start_edge = s3_q & ~s2_q;
  assign rx_sync    = s2_q;
  assign sample     = (bps_cnt_q == CW'(HALF_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      state_q   <= IDLE;
      bps_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rx_int_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      s1_q      <= rs232_rx;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      state_q   <= state_d;
      bps_cnt_q <= bps_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rx_int_q  <= rx_int_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rx_int_d  = rx_int_q;
    ferr_d    = 1'b0;

    // Bit timer is held at zero in IDLE, so entering START always starts
    // the count from 0.
    if (state_q == IDLE) begin
      bps_cnt_d = '0;
    end else if (bps_cnt_q == CW'(BPS_CNT - 1)) begin
      bps_cnt_d = '0;
    end else begin
      bps_cnt_d = bps_cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
        end
      end
      START: begin
        if (sample) begin
          if (!rx_sync) begin
            state_d   = DATA;
            bit_idx_d = '0;
            rx_int_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d[bit_idx_q] = rx_sync;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Leaving at the stop-bit midpoint lets a fast transmitter's next
        // start edge, arriving in the second half of the stop bit, be caught.
        if (sample) begin
          data_d   = shift_q;
          rx_int_d = 1'b0;
          ferr_d   = ~rx_sync;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_rx   = data_q;
  assign rx_int    = rx_int_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_hongwai_uart_rx.sv
`timescale 1ps/1ps
module tb_hongwai_uart_rx;

  localparam int CLK_HALF = 5000;           // 10 ns clock
  localparam int BIT_PS   = 16 * 2 * CLK_HALF; // 16 clocks per bit

  logic       clk;
  logic       rst_n;
  logic       rs232_rx;
  logic [7:0] data_rx;
  logic       rx_int;
  logic       frame_err;

  int n_cmp;
  int n_fail;

  // Observations collected by the monitor
  logic [7:0] obs_byte_q[$];
  logic       obs_ferr_q[$];
  int         obs_dur_q[$];
  int         rise_cnt;
  int         ferr_cycles;

  hongwai_uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (rs232_rx),
    .data_rx   (data_rx),
    .rx_int    (rx_int),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #(CLK_HALF) clk = ~clk;

  // Monitor: sample away from the active edge
  logic prev_int;
  int   cur_dur;
  initial begin
    prev_int    = 1'b0;
    cur_dur     = 0;
    rise_cnt    = 0;
    ferr_cycles = 0;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_int = 1'b0;
      cur_dur  = 0;
    end else begin
      if (frame_err === 1'b1) ferr_cycles++;
      if (rx_int === 1'b1) begin
        if (!prev_int) rise_cnt++;
        cur_dur++;
      end else if (prev_int) begin
        obs_byte_q.push_back(data_rx);
        obs_ferr_q.push_back(frame_err);
        obs_dur_q.push_back(cur_dur);
        cur_dur = 0;
      end
      prev_int = rx_int;
    end
  end

  // Serial transmitter: start, 8 data LSB first, stop, with bit period bp
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int bp);
    rs232_rx = 1'b0;
    #(bp);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      #(bp);
    end
    rs232_rx = stop_v;
    #(bp);
    rs232_rx = 1'b1;
  endtask

  task automatic idle_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (obs_byte_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (obs_byte_q.size() < n) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d frames expected %0d", name, obs_byte_q.size(), n);
    end
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    rs232_rx = 1'b1;
    idle_clk(5);
    rst_n = 1'b1;
    idle_clk(5);
    n_cmp++;
    if (data_rx !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_rx); end
    n_cmp++;
    if (rx_int !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b expected 0", rx_int); end
    n_cmp++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
  endtask

  task automatic test_single;
    int base, fbase;
    base  = obs_byte_q.size();
    fbase = ferr_cycles;
    send_byte(8'h41, 1'b1, BIT_PS);
    wait_frames(base + 1, 400, "single");
    idle_clk(20);
    n_cmp++;
    if (obs_byte_q.size() != base + 1) begin n_fail++; $display("FAIL single_count: got %0d expected %0d", obs_byte_q.size(), base + 1); end
    else begin
      n_cmp++;
      if (obs_byte_q[base] !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h expected 41", obs_byte_q[base]); end
      n_cmp++;
      // 8.5 to 9 bit times of 16 clocks
      if (obs_dur_q[base] < 130 || obs_dur_q[base] > 150) begin
        n_fail++; $display("FAIL single_dur: got %0d expected 130..150", obs_dur_q[base]);
      end
    end
    n_cmp++;
    if (ferr_cycles != fbase) begin n_fail++; $display("FAIL single_ferr: got %0d expected %0d", ferr_cycles - fbase, 0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[6];
    int base;
    exp_b = '{8'h41, 8'h42, 8'h43, 8'h30, 8'h36, 8'h35};
    base  = obs_byte_q.size();
    for (int i = 0; i < 6; i++) send_byte(exp_b[i], 1'b1, BIT_PS);
    wait_frames(base + 6, 400, "b2b");
    idle_clk(20);
    n_cmp++;
    if (obs_byte_q.size() != base + 6) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", obs_byte_q.size() - base, 6); end
    for (int i = 0; i < 6; i++) begin
      if (base + i < obs_byte_q.size()) begin
        n_cmp++;
        if (obs_byte_q[base + i] !== exp_b[i]) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, obs_byte_q[base + i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_glitch;
    int base, rbase;
    logic [7:0] held;
    base  = obs_byte_q.size();
    rbase = rise_cnt;
    held  = data_rx;
    rs232_rx = 1'b0;
    idle_clk(4);
    rs232_rx = 1'b1;
    idle_clk(200);
    n_cmp++;
    if (rise_cnt != rbase) begin n_fail++; $display("FAIL glitch_rise: got %0d expected 0", rise_cnt - rbase); end
    n_cmp++;
    if (obs_byte_q.size() != base) begin n_fail++; $display("FAIL glitch_frames: got %0d expected 0", obs_byte_q.size() - base); end
    n_cmp++;
    if (data_rx !== held) begin n_fail++; $display("FAIL glitch_data: got %h expected %h", data_rx, held); end
  endtask

  task automatic test_frame_err;
    int base, fbase, rbase;
    base  = obs_byte_q.size();
    fbase = ferr_cycles;
    // Stop bit low, then keep the line low for a long time
    rs232_rx = 1'b0;
    #(BIT_PS);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = (8'h55 >> i) & 1;
      #(BIT_PS);
    end
    rs232_rx = 1'b0;
    wait_frames(base + 1, 400, "ferr");
    rbase = rise_cnt;
    idle_clk(300);
    n_cmp++;
    if (ferr_cycles - fbase != 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cycles - fbase); end
    if (obs_byte_q.size() > base) begin
      n_cmp++;
      if (obs_byte_q[base] !== 8'h55) begin n_fail++; $display("FAIL ferr_data: got %h expected 55", obs_byte_q[base]); end
      n_cmp++;
      if (obs_ferr_q[base] !== 1'b1) begin n_fail++; $display("FAIL ferr_on_fall: got %b expected 1", obs_ferr_q[base]); end
    end
    n_cmp++;
    if (rise_cnt != rbase || obs_byte_q.size() != base + 1) begin
      n_fail++; $display("FAIL stuck_low: got %0d extra frames expected 0", obs_byte_q.size() - base - 1);
    end
    rs232_rx = 1'b1;
    idle_clk(50);
  endtask

  task automatic test_reset_midframe;
    int base;
    base = obs_byte_q.size();
    rs232_rx = 1'b0;
    #(BIT_PS);
    for (int i = 0; i < 4; i++) begin
      rs232_rx = (8'h39 >> i) & 1;
      #(BIT_PS);
    end
    rs232_rx = (8'h39 >> 4) & 1;
    #(BIT_PS / 2);
    @(negedge clk);
    n_cmp++;
    if (rx_int !== 1'b1) begin n_fail++; $display("FAIL rst_pre_int: got %b expected 1", rx_int); end
    rst_n = 1'b0;
    idle_clk(3);
    n_cmp++;
    if (rx_int !== 1'b0) begin n_fail++; $display("FAIL rst_int: got %b expected 0", rx_int); end
    rs232_rx = 1'b1;
    idle_clk(30);
    rst_n = 1'b1;
    idle_clk(10);
    n_cmp++;
    if (data_rx !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h expected 00", data_rx); end
    n_cmp++;
    if (obs_byte_q.size() != base) begin n_fail++; $display("FAIL rst_partial: got %0d frames expected 0", obs_byte_q.size() - base); end
    send_byte(8'h37, 1'b1, BIT_PS);
    wait_frames(base + 1, 400, "rst_next");
    if (obs_byte_q.size() > base) begin
      n_cmp++;
      if (obs_byte_q[base] !== 8'h37) begin n_fail++; $display("FAIL rst_next_data: got %h expected 37", obs_byte_q[base]); end
    end
    idle_clk(20);
  endtask

  task automatic test_skew;
    int base;
    int bp[2];
    logic [7:0] b[2];
    bp = '{BIT_PS * 103 / 100, BIT_PS * 97 / 100};
    b  = '{8'hA5, 8'h5A};
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 2; k++) begin
        base = obs_byte_q.size();
        send_byte(b[k], 1'b1, bp[s]);
        wait_frames(base + 1, 400, "skew");
        idle_clk(20);
        if (obs_byte_q.size() > base) begin
          n_cmp++;
          if (obs_byte_q[base] !== b[k] || obs_ferr_q[base] !== 1'b0) begin
            n_fail++; $display("FAIL skew[%0d][%0d]: got %h/%b expected %h/0", s, k, obs_byte_q[base], obs_ferr_q[base], b[k]);
          end
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    int base;
    logic [7:0] b;
    base = obs_byte_q.size();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 1'b1, BIT_PS);
      #($urandom_range(0, 30) * 2 * CLK_HALF);
    end
    wait_frames(base + 10, 400, "random");
    idle_clk(20);
    n_cmp++;
    if (obs_byte_q.size() != base + 10) begin n_fail++; $display("FAIL rand_count: got %0d expected 10", obs_byte_q.size() - base); end
    for (int i = 0; i < 10; i++) begin
      if (base + i < obs_byte_q.size()) begin
        n_cmp++;
        if (obs_byte_q[base + i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, obs_byte_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_skew();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
